// File: rtl/adder_bist_pkg.sv
// Shared types, default polynomials and next-state helpers
// for the broadcast-adder BIST slice.
package adder_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CHECK,
    DONE
  } state_e;

  localparam logic [32:0] LFSR_TAPS_D = 33'h1_0008_0000;
  localparam logic [32:0] LFSR_SEED_D = 33'h0_0000_0001;
  localparam logic [16:0] MISR_TAPS_D = 17'h1_2000;

  // Shift left by one, feed back the parity of the tapped bits.
  function automatic logic [63:0] shift_fb(
    input logic [63:0] s,
    input logic [63:0] taps,
    input int          w
  );
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ((s << 1) | {63'd0, ^(s & taps)}) & mask;
  endfunction

  function automatic logic [63:0] lfsr_next(
    input logic [63:0] s,
    input logic [63:0] taps,
    input int          w
  );
    return shift_fb(s, taps, w);
  endfunction

  function automatic logic [63:0] misr_next(
    input logic [63:0] s,
    input logic [63:0] taps,
    input logic [63:0] resp,
    input int          w
  );
    return shift_fb(s, taps, w) ^ resp;
  endfunction

endpackage

// File: rtl/adder_bist_ctrl_if.sv
// Pattern/response bus between the BIST controller
// and the adder under test.
interface adder_bist_ctrl_if #(
  parameter int N = 16
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output a, b, cin,
    input  sum, cout
  );

  modport slave (
    input  a, b, cin,
    output sum, cout
  );
endinterface

// File: rtl/adder_bist_ctrl_misr.sv
// Multiple-input signature register compacting
// one adder response per enabled cycle.
module bist_misr
  import adder_bist_pkg::*;
#(
  parameter int                MISR_W    = 17,
  parameter logic [MISR_W-1:0] MISR_TAPS = MISR_TAPS_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [MISR_W-1:0] resp,
  output logic [MISR_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (en) begin
      sig <= MISR_W'(misr_next(64'(sig),
                               64'(MISR_TAPS),
                               64'(resp),
                               MISR_W));
    end
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST controller: LFSR patterns into the adder, MISR
// compaction of responses, golden signature compare.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int                N            = 16,
  parameter int                NUM_PATTERNS = 256,
  parameter int                LFSR_W       = 2*N+1,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = LFSR_TAPS_D,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_SEED_D,
  parameter int                MISR_W       = N+1,
  parameter logic [MISR_W-1:0] MISR_TAPS    = MISR_TAPS_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MISR_W-1:0] golden_sig,
  adder_bist_ctrl_if.master adder,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_LOAD  = LOAD;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_CHECK = CHECK;
  localparam logic [2:0] S_DONE  = DONE;

  localparam int            CW   = $clog2(NUM_PATTERNS+1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS-1);

  logic [2:0]        state;
  logic [LFSR_W-1:0] lfsr;
  logic [CW-1:0]     cnt;
  logic              run;
  logic              load;

  assign run  = (state == S_RUN);
  assign load = (state == S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      lfsr  <= '0;
      cnt   <= '0;
      pass  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          lfsr  <= LFSR_SEED;
          cnt   <= '0;
          pass  <= 1'b0;
          state <= S_RUN;
        end
        S_RUN: begin
          lfsr <= LFSR_W'(lfsr_next(64'(lfsr),
                                    64'(LFSR_TAPS),
                                    LFSR_W));
          cnt  <= cnt + CW'(1);
          // Exit on the edge that compacts the last response.
          if (cnt == LAST) state <= S_CHECK;
        end
        S_CHECK: begin
          pass  <= (signature == golden_sig);
          state <= S_DONE;
        end
        S_DONE: begin
          if (start) state <= S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign adder.a   = run ? lfsr[N-1:0]   : '0;
  assign adder.b   = run ? lfsr[2*N-1:N] : '0;
  assign adder.cin = run ? lfsr[2*N]     : 1'b0;

  assign busy = (state == S_LOAD)
              | (state == S_RUN)
              | (state == S_CHECK);
  assign done = (state == S_DONE);

  bist_misr #(
    .MISR_W    (MISR_W),
    .MISR_TAPS (MISR_TAPS)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (load),
    .en    (run),
    .resp  ({adder.cout, adder.sum}),
    .sig   (signature)
  );

  seed_nonzero: assert property (
    @(posedge clk) disable iff (!rst_n)
    load |-> (LFSR_SEED != '0)
  );

endmodule

// File: doc/adder_bist_ctrl.md
Name: adder_bist_ctrl

Overview:
Built-in self-test controller for the N-bit broadcast adder test structure. An LFSR sequences pseudo-random operand patterns (a, b, cin) into the adder datapath. Each combinational response {cout, sum} is compacted into a MISR. The final signature is compared against a golden value. The block sits between the tester pins and the adder and replaces manual pin toggling with a self-checking run.

Parameters:
N, 16, adder operand width
NUM_PATTERNS, 256, patterns applied per run (>=1)
LFSR_W, 2*N+1, pattern generator width (a, b, cin)
LFSR_TAPS, 33'h1_0008_0000, feedback mask (x^33+x^20+1 at default N)
LFSR_SEED, 33'h0_0000_0001, LFSR load value (must be nonzero)
MISR_W, N+1, signature width
MISR_TAPS, 17'h1_2000, MISR feedback mask (x^17+x^14+1 at default N)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a run; honoured in IDLE or DONE only
golden_sig  in  MISR_W  expected signature; sampled in CHECK
sum  in  N  adder sum response
cout  in  1  adder carry response
a  out  N  operand A to adder
b  out  N  operand B to adder
cin  out  1  carry-in to adder
busy  out  1  high in LOAD, RUN, CHECK
done  out  1  high in DONE
pass  out  1  valid when done; 1 means signature == golden_sig
signature  out  MISR_W  current MISR contents

Behaviour:
- Reset (async, rst_n=0): state=IDLE; lfsr=0; misr=0; cnt=0; pass=0. All outputs 0.
- States and transitions:
  - IDLE: start -> LOAD.
  - LOAD (1 cycle): lfsr<=LFSR_SEED; misr<=0; cnt<=0; pass<=0 -> RUN.
  - RUN: one pattern per cycle; after cnt reaches NUM_PATTERNS -> CHECK.
  - CHECK (1 cycle): pass<=(misr==golden_sig) -> DONE.
  - DONE: holds pass and signature; start -> LOAD; otherwise stay.
- Pattern mapping: a=lfsr[N-1:0], b=lfsr[2N-1:N], cin=lfsr[2N].
  - Driven only in RUN; a, b and cin are 0 in all other states.
- Response capture: the adder is combinational. Each RUN cycle samples the response of the currently driven pattern at the next edge, so there is no pipeline delay.
- LFSR advance, each RUN edge: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
- MISR update, each RUN edge: misr <= {misr[MISR_W-2:0], ^(misr & MISR_TAPS)} ^ {cout, sum}.
- Counter: cnt width is $clog2(NUM_PATTERNS+1). It increments each RUN edge. RUN exits on the edge where cnt becomes NUM_PATTERNS, so exactly NUM_PATTERNS responses are compacted.
- Latency: start seen at edge E0 -> LOAD at E0 -> first pattern after E1 -> done rises after edge E(NUM_PATTERNS+2).
- Boundary conditions:
  - start while busy: ignored, with no restart or state corruption.
  - start held high in DONE: restarts every time DONE is reached.
  - golden_sig changing during RUN: has no effect; only its CHECK-cycle value matters.
  - rst_n low mid-run: all state and outputs go to reset values immediately; a new start is required.
  - LFSR_SEED=0: illegal configuration; an assertion flags it in simulation.
- The signature output is visible live during RUN and frozen in DONE.

Decomposition:
- Shared package adder_bist_pkg holds:
  - state enum {IDLE, LOAD, RUN, CHECK, DONE};
  - default LFSR_TAPS, MISR_TAPS and LFSR_SEED constants for N=16;
  - a pure next-state function for the LFSR and the MISR, reused by the bench reference model.
- One natural sub-module: bist_misr, parameterised MISR_W and MISR_TAPS, with ports clk, rst_n, clear, en, resp, sig.
  - The controller instances it and holds the FSM, LFSR and counter itself.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> busy=0, done=0, pass=0, a=b=0, cin=0, signature=0.
- Pattern sequence (NUM_PATTERNS=3, seed=1, fault-free adder): first three RUN cycles drive a=16'h0001, 16'h0002, 16'h0004 with b=0, cin=0. Done rises 5 edges after the start edge; signature=17'h00004.
- Golden compare: same run with golden_sig=17'h00004 -> pass=1; golden_sig=17'h00005 -> pass=0.
- Fault detect: sum[0] stuck-at-0, NUM_PATTERNS=3, golden 17'h00004 -> signature=17'h00000, pass=0.
- start pulsed during RUN -> run length unchanged and done timing identical to the unpulsed run. start in DONE -> done drops, LOAD, and the identical signature is reproduced.
- rst_n asserted mid-RUN (default params, cycle 100) -> outputs immediately 0, state IDLE. The next start completes after 258 edges with a signature matching the reference model.
